// File: rtl/store_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_sequencer
//
// Queues store requests from the core's store path and issues them as
// word-aligned, lane-positioned write beats on the data-memory write port over
// a valid/ready handshake. sw/sb/sh are widened into data, byte strobes and a
// word address; a store whose bytes run past the end of its word is a
// boundary-crossing store.
//
// Build option (macro STORE_SPLIT_EN):
//   defined   - boundary-crossing stores issue two beats (beat0 then beat1).
//   undefined - boundary-crossing stores are dropped and misalign_err pulses.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready store request handshake (ready = queue not full)
//   req_addr        byte address of the store
//   req_data        store data (source register value)
//   req_sel         00 sw, 01 sb, 10 sh, 11 treated as sw
//   mem_valid/ready write beat handshake
//   mem_addr        word-aligned beat address
//   mem_wdata       lane-positioned write data
//   mem_wstrb       byte enables
//   busy            queue non-empty or beat in flight
//   misalign_err    one-cycle pulse when a boundary-crossing store is dropped
// -----------------------------------------------------------------------------
module store_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_sel,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1
`ifdef STORE_SPLIT_EN
    , BEAT1 = 2'd2
`endif
  } state_t;

  state_t state, state_next;

  entry_t          fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            ready_en;
  logic            full, empty, push, pop;
  entry_t          head;

  logic [31:0]     ext;
  logic [3:0]      mask;
  logic [1:0]      off;
  logic [7:0]      m8;
  logic            crossing;
  logic [31:0]     beat0_wdata;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  // ready_en holds req_ready low through reset and rises on the first edge after.
  assign req_ready = ready_en && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign mem_valid = (state != IDLE);
  assign busy      = !empty || (state != IDLE);

  // NOTE: storage has no reset; only pointers and count define which entries
  // are live, so clearing the array would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: req_addr, data: req_data, sel: req_sel};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Lane formation for the head entry.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    ext  = head.data;
    mask = 4'b1111;
    case (head.sel)
      2'b01: begin ext = {24'b0, head.data[7:0]};  mask = 4'b0001; end
      2'b10: begin ext = {16'b0, head.data[15:0]}; mask = 4'b0011; end
      default: ;
    endcase
    off         = head.addr[1:0];
    m8          = {4'b0000, mask} << off;
    crossing    = |m8[7:4];
    beat0_wdata = ext << {off, 3'b000};
  end

`ifdef STORE_SPLIT_EN
  logic [31:0] beat1_wdata;
  logic [31:0] b1_wdata;
  logic [3:0]  b1_wstrb;
  logic        split_pend;

  // Upper lanes that spilled past the word; off=0 never crosses, so the
  // shift-by-32 case is never used.
  assign beat1_wdata  = ext >> {3'd4 - {1'b0, off}, 3'b000};
  assign misalign_err = 1'b0;
`else
  logic err_q;
  assign misalign_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef STORE_SPLIT_EN
        if (!empty) state_next = BEAT0;
`else
        // A dropped crossing store is popped but issues no beat.
        if (!empty && !crossing) state_next = BEAT0;
`endif
      end
      BEAT0: begin
`ifdef STORE_SPLIT_EN
        if (mem_ready) state_next = split_pend ? BEAT1 : IDLE;
`else
        if (mem_ready) state_next = IDLE;
`endif
      end
`ifdef STORE_SPLIT_EN
      BEAT1: if (mem_ready) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Beat registers: loaded at pop, held while stalled, swapped to beat1 fields
  // when beat0 is accepted on a split store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
`ifdef STORE_SPLIT_EN
      b1_wdata   <= '0;
      b1_wstrb   <= '0;
      split_pend <= 1'b0;
`else
      err_q      <= 1'b0;
`endif
    end else begin
      if (pop) begin
        mem_addr  <= {head.addr[31:2], 2'b00};
        mem_wdata <= beat0_wdata;
        mem_wstrb <= m8[3:0];
      end
`ifdef STORE_SPLIT_EN
      if (pop) begin
        b1_wdata   <= beat1_wdata;
        b1_wstrb   <= m8[7:4];
        split_pend <= crossing;
      end
      if ((state == BEAT0) && mem_ready && split_pend) begin
        mem_addr  <= mem_addr + 32'd4;
        mem_wdata <= b1_wdata;
        mem_wstrb <= b1_wstrb;
      end
`else
      err_q <= pop && crossing;
`endif
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
`timescale 1ns/1ps
// Testbench for store_sequencer: directed cases with hand-written expected
// beats, then randomized traffic checked against a byte-level reference model.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_sel;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        misalign_err;

  store_sequencer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_sel      (req_sel),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    rand_mode = 1'b0;
  bit    ready_force = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void expect_beat(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    beat_t b;
    b.err = 1'b0; b.addr = a; b.wdata = w; b.wstrb = s;
    exp_q.push_back(b);
  endfunction

  function automatic void expect_err();
    beat_t b;
    b.err = 1'b1; b.addr = '0; b.wdata = '0; b.wstrb = '0;
    exp_q.push_back(b);
  endfunction

  // Reference model: place each stored byte at its own byte address, then
  // group bytes by the word they land in.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int    nbytes;
    int    lane;
    beat_t b0, b1;
    nbytes = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
    if ((a % 4) + nbytes > 4) begin
`ifndef STORE_SPLIT_EN
      expect_err();
      return;
`endif
    end
    b0.err = 1'b0; b0.addr = a & ~32'd3;          b0.wdata = '0; b0.wstrb = '0;
    b1.err = 1'b0; b1.addr = (a & ~32'd3) + 32'd4; b1.wdata = '0; b1.wstrb = '0;
    for (int i = 0; i < nbytes; i++) begin
      lane = int'(a % 4) + i;
      if (lane < 4) begin
        b0.wdata[8*lane +: 8] = d[8*i +: 8];
        b0.wstrb[lane] = 1'b1;
      end else begin
        b1.wdata[8*(lane-4) +: 8] = d[8*i +: 8];
        b1.wstrb[lane-4] = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (b1.wstrb != 4'b0000) exp_q.push_back(b1);
  endfunction

  // mem_ready driver: random in random mode, else the directed level.
  always @(negedge clk) begin
    #1;
    mem_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: scoreboard for accepted beats and error pulses, plus hold checks.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;
  beat_t       mon_e;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(mem_valid), 32'd1);
        check("hold_addr",  mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
        check("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
      end
      if (misalign_err) begin
        check("err_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("err_kind", 32'(mon_e.err), 32'd1);
        end
      end
      if (mem_valid && mem_ready) begin
        check("beat_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("beat_kind",  32'(mon_e.err), 32'd0);
          check("beat_addr",  mem_addr, mon_e.addr);
          check("beat_wdata", mem_wdata, mon_e.wdata);
          check("beat_wstrb", 32'(mem_wstrb), 32'(mon_e.wstrb));
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_wstrb = mem_wstrb;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      output int waited);
    req_addr = a; req_data = d; req_sel = s; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("send_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy",  32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int k;
    logic [31:0] a, d;
    logic [1:0]  s;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_err",       32'(misalign_err), 32'd0);
    check("rst_addr",      mem_addr, 32'd0);
    check("rst_wdata",     mem_wdata, 32'd0);
    check("rst_wstrb",     32'(mem_wstrb), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_post_edge", 32'(req_ready), 32'd1);

    // sw with latency: accepted at E, valid seen at E+2.
    ready_force = 1'b1;
    expect_beat(32'h100, 32'hDEADBEEF, 4'b1111);
    send(32'h100, 32'hDEADBEEF, 2'b00, w);
    check("lat_e1", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("lat_e2", 32'(mem_valid), 32'd1);
    wait_idle(50);

    // sb, sh within a word, sel=11 as sw.
    expect_beat(32'h200, 32'hAB000000, 4'b1000);
    send(32'h203, 32'h123456AB, 2'b01, w);
    expect_beat(32'h300, 32'h00CAFE00, 4'b0110);
    send(32'h301, 32'hFFFFCAFE, 2'b10, w);
    expect_beat(32'h010, 32'hCAFEF00D, 4'b1111);
    send(32'h010, 32'hCAFEF00D, 2'b11, w);
    wait_idle(50);

    // Boundary-crossing sw.
`ifdef STORE_SPLIT_EN
    expect_beat(32'h400, 32'h33440000, 4'b1100);
    expect_beat(32'h404, 32'h00001122, 4'b0011);
`else
    expect_err();
`endif
    send(32'h402, 32'h11223344, 2'b00, w);
    wait_idle(50);

    // Stall: first store sits in BEAT0, four more fill the queue.
    ready_force = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      expect_beat(32'h600 + 32'(4*i), d, 4'b1111);
      send(32'h600 + 32'(4*i), d, 2'b00, w);
      check("stall_accept_wait", 32'(w), 32'd0);
    end
    check("full_ready", 32'(req_ready), 32'd0);
    check("stall_valid", 32'(mem_valid), 32'd1);
    check("stall_busy",  32'(busy), 32'd1);
    check("stall_addr",  mem_addr, 32'h600);
    req_addr = 32'h800; req_data = 32'h5A5A5A5A; req_sel = 2'b00; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    ready_force = 1'b1;
    wait_idle(100);

    // Address wrap on the top word.
`ifdef STORE_SPLIT_EN
    expect_beat(32'hFFFFFFFC, 32'hC3D40000, 4'b1100);
    expect_beat(32'h00000000, 32'h0000A1B2, 4'b0011);
`else
    expect_err();
`endif
    send(32'hFFFFFFFE, 32'hA1B2C3D4, 2'b00, w);
    wait_idle(50);

    // Reset while stalled in BEAT0 with another store queued.
    ready_force = 1'b0;
    @(negedge clk);
    expect_beat(32'h700, 32'h01020304, 4'b1111);
    send(32'h700, 32'h01020304, 2'b00, w);
    expect_beat(32'h704, 32'h05060708, 4'b1111);
    send(32'h704, 32'h05060708, 2'b00, w);
    k = 0;
    while (!mem_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_valid", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    ready_force = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_valid", 32'(mem_valid), 32'd0);
    check("post_rst_busy",  32'(busy), 32'd0);

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      d = $urandom;
      model(a, d, s);
      send(a, d, s, w);
    end
    rand_mode = 1'b0;
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
